// File: rtl/msb_strm_rst_ctrl.sv
// Stream-reset controller for the multi-stream buffer: accepts single/broadcast reset commands,
// issues them to the L2 channels round-robin, collects L1 completion and holds stream-ready until taken.
module msb_strm_rst_ctrl #(
    parameter int addr_width      = 64,
    parameter int nstrms          = 64,
    parameter int nstrms_width    = $clog2(nstrms),
    parameter int channels        = 4,
    parameter int l2_nstrms       = nstrms / channels,
    parameter int l2_nstrms_width = $clog2(l2_nstrms),
    parameter int stride_shift    = 20
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 i_rst_v,
    output logic                                 i_rst_r,
    input  logic                                 i_rst_all,
    input  logic [nstrms_width-1:0]              i_rst_sid,
    input  logic [addr_width-1:0]                i_rst_ea,
    output logic [channels-1:0]                  o_ch_v,
    input  logic [channels-1:0]                  o_ch_r,
    output logic [channels*l2_nstrms_width-1:0]  o_ch_sid,
    output logic [channels*addr_width-1:0]       o_ch_ea,
    input  logic [nstrms-1:0]                    i_done_v,
    output logic [nstrms-1:0]                    i_done_r,
    output logic [nstrms-1:0]                    o_rst_v,
    input  logic [nstrms-1:0]                    o_rst_r,
    output logic [nstrms-1:0]                    o_busy,
    output logic                                 o_quiet
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PEND  = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_READY = 2'd3;

    logic [1:0]                 state_q   [nstrms];
    logic [1:0]                 state_d   [nstrms];
    logic [addr_width-1:0]      ea_q      [nstrms];
    logic [addr_width-1:0]      ea_d      [nstrms];

    logic [channels-1:0]        out_v_q;
    logic [channels-1:0]        out_v_d;
    logic [l2_nstrms_width-1:0] out_sid_q [channels];
    logic [l2_nstrms_width-1:0] out_sid_d [channels];
    logic [addr_width-1:0]      out_ea_q  [channels];
    logic [addr_width-1:0]      out_ea_d  [channels];
    logic [l2_nstrms_width-1:0] ptr_q     [channels];
    logic [l2_nstrms_width-1:0] ptr_d     [channels];

    logic [channels-1:0]        load;
    logic [channels-1:0]        win_v;
    logic [l2_nstrms_width-1:0] win_sid   [channels];

    logic                       all_ok;
    logic                       one_ok;
    logic                       cmd_ok;
    logic                       cmd_acc;

    // Channel-local index 'off' positions after 'base', wrapping within the channel.
    function automatic logic [l2_nstrms_width-1:0] rr_idx(input logic [l2_nstrms_width-1:0] base,
                                                          input int off);
        return l2_nstrms_width'((int'(base) + off) % l2_nstrms);
    endfunction

    // Per-channel round-robin arbiter feeding a one-entry output register.
    always_comb begin
        for (int c = 0; c < channels; c++) begin
            // NOTE: every combinational output gets a default before any branch, otherwise a latch is inferred.
            win_v[c]     = 1'b0;
            win_sid[c]   = '0;
            load[c]      = ~out_v_q[c] | o_ch_r[c];
            out_v_d[c]   = out_v_q[c];
            out_sid_d[c] = out_sid_q[c];
            out_ea_d[c]  = out_ea_q[c];
            ptr_d[c]     = ptr_q[c];
            for (int i = 0; i < l2_nstrms; i++) begin
                if (!win_v[c] && state_q[c*l2_nstrms + int'(rr_idx(ptr_q[c], i))] == ST_PEND) begin
                    win_v[c]   = 1'b1;
                    win_sid[c] = rr_idx(ptr_q[c], i);
                end
            end
            if (load[c]) begin
                out_v_d[c] = win_v[c];
                if (win_v[c]) begin
                    out_sid_d[c] = win_sid[c];
                    out_ea_d[c]  = ea_q[c*l2_nstrms + int'(win_sid[c])];
                    ptr_d[c]     = rr_idx(win_sid[c], 1);
                end
            end
        end
    end

    // Command acceptance and per-stream next state; an accepted command overrides any other transition.
    always_comb begin
        all_ok = 1'b1;
        for (int s = 0; s < nstrms; s++) begin
            if (state_q[s] == ST_PEND || state_q[s] == ST_BUSY) all_ok = 1'b0;
        end
        one_ok  = (state_q[i_rst_sid] == ST_IDLE) || (state_q[i_rst_sid] == ST_READY);
        cmd_ok  = ~reset & (i_rst_all ? all_ok : one_ok);
        cmd_acc = i_rst_v & cmd_ok;

        for (int s = 0; s < nstrms; s++) begin
            state_d[s] = state_q[s];
            ea_d[s]    = ea_q[s];
            case (state_q[s])
                ST_PEND: begin
                    if (load[s / l2_nstrms] && win_v[s / l2_nstrms] &&
                        win_sid[s / l2_nstrms] == l2_nstrms_width'(s % l2_nstrms))
                        state_d[s] = ST_BUSY;
                end
                ST_BUSY:  if (i_done_v[s]) state_d[s] = ST_READY;
                ST_READY: if (o_rst_r[s])  state_d[s] = ST_IDLE;
                default: ;
            endcase
            if (cmd_acc && (i_rst_all || i_rst_sid == nstrms_width'(s))) begin
                state_d[s] = ST_PEND;
                ea_d[s]    = i_rst_all ? i_rst_ea + (addr_width'(s) << stride_shift) : i_rst_ea;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the EA array is a small flop bank, not a RAM, so it is cleared along with the state.
            for (int s = 0; s < nstrms; s++) begin
                state_q[s] <= ST_IDLE;
                ea_q[s]    <= '0;
            end
            out_v_q <= '0;
            for (int c = 0; c < channels; c++) begin
                out_sid_q[c] <= '0;
                out_ea_q[c]  <= '0;
                ptr_q[c]     <= '0;
            end
        end else begin
            for (int s = 0; s < nstrms; s++) begin
                state_q[s] <= state_d[s];
                ea_q[s]    <= ea_d[s];
            end
            out_v_q <= out_v_d;
            for (int c = 0; c < channels; c++) begin
                out_sid_q[c] <= out_sid_d[c];
                out_ea_q[c]  <= out_ea_d[c];
                ptr_q[c]     <= ptr_d[c];
            end
        end
    end

    always_comb begin
        o_busy   = '0;
        i_done_r = '0;
        o_rst_v  = '0;
        o_ch_sid = '0;
        o_ch_ea  = '0;
        for (int s = 0; s < nstrms; s++) begin
            o_busy[s]   = (state_q[s] == ST_PEND) || (state_q[s] == ST_BUSY);
            i_done_r[s] = (state_q[s] == ST_BUSY);
            o_rst_v[s]  = (state_q[s] == ST_READY);
        end
        for (int c = 0; c < channels; c++) begin
            o_ch_sid[c*l2_nstrms_width +: l2_nstrms_width] = out_sid_q[c];
            o_ch_ea[c*addr_width +: addr_width]            = out_ea_q[c];
        end
    end

    assign o_ch_v  = out_v_q;
    assign o_quiet = ~|o_busy;
    assign i_rst_r = cmd_ok;

endmodule

// File: tb/tb_msb_strm_rst_ctrl.sv
// Bench for msb_strm_rst_ctrl: channel issues are checked by a scoreboard monitor,
// stream status and handshake rules by directed checks.
module tb_msb_strm_rst_ctrl;

    localparam int AW  = 64;
    localparam int NS  = 64;
    localparam int NSW = 6;
    localparam int CH  = 4;
    localparam int L2  = 16;
    localparam int L2W = 4;
    localparam int SS  = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_rst_v;
    logic              i_rst_r;
    logic              i_rst_all;
    logic [NSW-1:0]    i_rst_sid;
    logic [AW-1:0]     i_rst_ea;
    logic [CH-1:0]     o_ch_v;
    logic [CH-1:0]     o_ch_r;
    logic [CH*L2W-1:0] o_ch_sid;
    logic [CH*AW-1:0]  o_ch_ea;
    logic [NS-1:0]     i_done_v;
    logic [NS-1:0]     i_done_r;
    logic [NS-1:0]     o_rst_v;
    logic [NS-1:0]     o_rst_r;
    logic [NS-1:0]     o_busy;
    logic              o_quiet;

    typedef struct packed {
        logic [L2W-1:0] sid;
        logic [AW-1:0]  ea;
    } issue_t;

    issue_t exp_q [CH][$];
    int checks   = 0;
    int failures = 0;

    msb_strm_rst_ctrl #(
        .addr_width(AW), .nstrms(NS), .channels(CH), .stride_shift(SS)
    ) dut (
        .clk(clk), .reset(reset),
        .i_rst_v(i_rst_v), .i_rst_r(i_rst_r), .i_rst_all(i_rst_all),
        .i_rst_sid(i_rst_sid), .i_rst_ea(i_rst_ea),
        .o_ch_v(o_ch_v), .o_ch_r(o_ch_r), .o_ch_sid(o_ch_sid), .o_ch_ea(o_ch_ea),
        .i_done_v(i_done_v), .i_done_r(i_done_r),
        .o_rst_v(o_rst_v), .o_rst_r(o_rst_r),
        .o_busy(o_busy), .o_quiet(o_quiet)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every channel handshake pops and compares the oldest expected issue.
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < CH; c++) begin
                if (o_ch_v[c] && o_ch_r[c]) begin
                    if (exp_q[c].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL ch%0d_unexpected: got sid %0d ea 0x%0h, none expected",
                                 c, o_ch_sid[c*L2W +: L2W], o_ch_ea[c*AW +: AW]);
                    end else begin
                        issue_t e;
                        e = exp_q[c].pop_front();
                        check($sformatf("ch%0d_sid", c), 128'(o_ch_sid[c*L2W +: L2W]), 128'(e.sid));
                        check($sformatf("ch%0d_ea", c),  128'(o_ch_ea[c*AW +: AW]),    128'(e.ea));
                    end
                end
            end
        end
    end

    task automatic push_exp(input int s, input logic [AW-1:0] ea);
        issue_t e;
        e.sid = L2W'(s % L2);
        e.ea  = ea;
        exp_q[s / L2].push_back(e);
    endtask

    // Waits (bounded) for ready, completes one command handshake and records the expected issues.
    task automatic send_cmd(input logic all, input int sid, input logic [AW-1:0] ea);
        int n = 0;
        i_rst_v   = 1'b1;
        i_rst_all = all;
        i_rst_sid = NSW'(sid);
        i_rst_ea  = ea;
        #1;
        while (!i_rst_r && n < 100) begin
            tick();
            n++;
        end
        check($sformatf("cmd_ready_sid%0d", sid), 128'(i_rst_r), 128'(1));
        if (all) begin
            for (int s = 0; s < NS; s++) push_exp(s, ea + (AW'(s) << SS));
        end else begin
            push_exp(sid, ea);
        end
        tick();
        i_rst_v   = 1'b0;
        i_rst_all = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int all_v_cycles;
        reset     = 1'b1;
        i_rst_v   = 1'b0;
        i_rst_all = 1'b0;
        i_rst_sid = '0;
        i_rst_ea  = '0;
        o_ch_r    = '0;
        i_done_v  = '0;
        o_rst_r   = '0;
        tick();
        tick();

        // Reset state
        check("rst_ch_v",   128'(o_ch_v),   128'(0));
        check("rst_rst_v",  128'(o_rst_v),  128'(0));
        check("rst_busy",   128'(o_busy),   128'(0));
        check("rst_done_r", 128'(i_done_r), 128'(0));
        check("rst_cmd_r",  128'(i_rst_r),  128'(0));
        check("rst_quiet",  128'(o_quiet),  128'(1));
        reset = 1'b0;
        #1;
        check("post_rst_cmd_r", 128'(i_rst_r), 128'(1));

        // 1. Single reset of stream 5
        o_ch_r = 4'hF;
        send_cmd(1'b0, 5, 64'h1000);
        check("t1_pend_no_issue", 128'(o_ch_v),    128'(0));
        check("t1_pend_busy",     128'(o_busy[5]), 128'(1));
        check("t1_pend_quiet",    128'(o_quiet),   128'(0));
        tick();
        check("t1_issue_v",  128'(o_ch_v),      128'(4'b0001));
        check("t1_done_r",   128'(i_done_r[5]), 128'(1));
        check("t1_busy",     128'(o_busy[5]),   128'(1));
        tick();
        check("t1_issue_gone", 128'(o_ch_v), 128'(0));
        i_done_v[5] = 1'b1;
        tick();
        i_done_v[5] = 1'b0;
        check("t1_ready",      128'(o_rst_v), 128'(64'h20));
        check("t1_ready_busy", 128'(o_busy),  128'(0));
        tick();
        tick();
        check("t1_ready_held", 128'(o_rst_v[5]), 128'(1));
        o_rst_r[5] = 1'b1;
        tick();
        o_rst_r[5] = 1'b0;
        check("t1_idle_rst_v", 128'(o_rst_v[5]), 128'(0));
        check("t1_idle_quiet", 128'(o_quiet),    128'(1));

        // 2. Broadcast from a fresh reset so every pointer starts at local sid 0
        check("t2_q_empty_before", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 128'(0));
        do_reset();
        send_cmd(1'b1, 0, 64'h0);
        check("t2_latency_no_issue", 128'(o_ch_v), 128'(0));
        i_rst_all = 1'b1;
        #1;
        check("t2_bcast_blocked_pend", 128'(i_rst_r), 128'(0));
        i_rst_all = 1'b0;
        tick();
        all_v_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            if (o_ch_v == 4'hF) all_v_cycles++;
            if (i == 1) begin
                check("t2_s17_sid", 128'(o_ch_sid[1*L2W +: L2W]), 128'(1));
                check("t2_s17_ea",  128'(o_ch_ea[1*AW +: AW]),    128'(64'h0110_0000));
            end
            tick();
        end
        check("t2_issue_cycles", 128'(all_v_cycles), 128'(16));
        check("t2_drained_v",    128'(o_ch_v),       128'(0));
        check("t2_q_empty", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 128'(0));
        i_rst_all = 1'b1;
        #1;
        check("t2_bcast_blocked_busy", 128'(i_rst_r), 128'(0));
        i_rst_all = 1'b0;
        i_done_v  = '1;
        tick();
        i_done_v  = '0;
        check("t2_all_ready", 128'(o_rst_v), 128'(64'hFFFF_FFFF_FFFF_FFFF));
        i_rst_all = 1'b1;
        #1;
        check("t2_bcast_ok_ready", 128'(i_rst_r), 128'(1));
        i_rst_all = 1'b0;
        o_rst_r   = '1;
        tick();
        o_rst_r   = '0;
        check("t2_all_idle", 128'(o_rst_v), 128'(0));
        check("t2_quiet",    128'(o_quiet), 128'(1));

        // 3. Backpressure on channel 2 while the other channels keep issuing
        do_reset();
        o_ch_r = 4'b1011;
        send_cmd(1'b0, 32, 64'h2000_0000);
        send_cmd(1'b0, 33, 64'h2100_0000);
        send_cmd(1'b0, 1,  64'h0001_0000);
        send_cmd(1'b0, 17, 64'h0011_0000);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_ch2_v_%0d", i),   128'(o_ch_v[2]),                128'(1));
            check($sformatf("t3_ch2_sid_%0d", i), 128'(o_ch_sid[2*L2W +: L2W]),   128'(0));
            check($sformatf("t3_ch2_ea_%0d", i),  128'(o_ch_ea[2*AW +: AW]),      128'(64'h2000_0000));
            tick();
        end
        check("t3_other_ch_drained", 128'(exp_q[0].size() + exp_q[1].size() + exp_q[3].size()), 128'(0));
        check("t3_s33_pend_busy",   128'(o_busy[33]),   128'(1));
        check("t3_s33_pend_done_r", 128'(i_done_r[33]), 128'(0));
        o_ch_r = 4'hF;
        tick();
        check("t3_release_v",   128'(o_ch_v[2]),              128'(1));
        check("t3_release_sid", 128'(o_ch_sid[2*L2W +: L2W]), 128'(1));
        check("t3_release_ea",  128'(o_ch_ea[2*AW +: AW]),    128'(64'h2100_0000));
        tick();
        check("t3_q_empty", 128'(exp_q[2].size()), 128'(0));

        // 4. Collisions on stream 9
        do_reset();
        send_cmd(1'b0, 9, 64'h9000);
        tick();
        check("t4_busy_done_r", 128'(i_done_r[9]), 128'(1));
        i_rst_v   = 1'b1;
        i_rst_sid = NSW'(9);
        i_rst_ea  = 64'h9999;
        #1;
        check("t4_busy_blocks", 128'(i_rst_r), 128'(0));
        tick();
        tick();
        check("t4_still_blocked", 128'(i_rst_r),   128'(0));
        check("t4_still_busy",    128'(o_busy[9]), 128'(1));
        i_rst_v     = 1'b0;
        i_done_v[9] = 1'b1;
        tick();
        i_done_v[9] = 1'b0;
        check("t4_ready", 128'(o_rst_v[9]), 128'(1));
        tick();
        check("t4_ready_held", 128'(o_rst_v[9]), 128'(1));
        send_cmd(1'b0, 9, 64'h9100);
        check("t4_rereset_drop", 128'(o_rst_v[9]), 128'(0));
        check("t4_rereset_pend", 128'(o_busy[9]),  128'(1));
        tick();
        i_done_v[9] = 1'b1;
        tick();
        i_done_v[9] = 1'b0;
        check("t4_ready2", 128'(o_rst_v[9]), 128'(1));
        o_rst_r[9] = 1'b1;
        send_cmd(1'b0, 9, 64'h9200);
        o_rst_r[9] = 1'b0;
        check("t4_cmd_wins_busy",  128'(o_busy[9]),  128'(1));
        check("t4_cmd_wins_rst_v", 128'(o_rst_v[9]), 128'(0));
        tick();
        i_done_v[9] = 1'b1;
        tick();
        i_done_v[9] = 1'b0;
        o_rst_r[9]  = 1'b1;
        tick();
        o_rst_r[9]  = 1'b0;
        check("t4_quiet", 128'(o_quiet), 128'(1));
        check("t4_q_empty", 128'(exp_q[0].size()), 128'(0));

        // 5. Reset in the middle of operation
        o_ch_r = '0;
        send_cmd(1'b0, 2,  64'hA000);
        send_cmd(1'b0, 18, 64'hB000);
        send_cmd(1'b0, 34, 64'hC000);
        tick();
        check("t5_pre_ch_v",  128'(o_ch_v), 128'(4'b0111));
        check("t5_pre_busy3", 128'({i_done_r[34], i_done_r[18], i_done_r[2]}), 128'(3'b111));
        check("t5_pre_quiet", 128'(o_quiet), 128'(0));
        reset = 1'b1;
        tick();
        for (int c = 0; c < CH; c++) exp_q[c].delete();
        check("t5_ch_v",   128'(o_ch_v),   128'(0));
        check("t5_busy",   128'(o_busy),   128'(0));
        check("t5_rst_v",  128'(o_rst_v),  128'(0));
        check("t5_done_r", 128'(i_done_r), 128'(0));
        check("t5_cmd_r",  128'(i_rst_r),  128'(0));
        check("t5_quiet",  128'(o_quiet),  128'(1));
        reset       = 1'b0;
        i_done_v[2] = 1'b1;
        #1;
        check("t5_stray_done_r", 128'(i_done_r[2]), 128'(0));
        tick();
        i_done_v[2] = 1'b0;
        check("t5_stray_rst_v", 128'(o_rst_v), 128'(0));
        check("t5_stray_quiet", 128'(o_quiet), 128'(1));
        check("t5_stray_ch_v",  128'(o_ch_v),  128'(0));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
